// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sample type, default width and window-buffer FSM states
package cnn_pkg;
    localparam int DEF_DW = 18;
    typedef logic signed [DEF_DW-1:0] sample_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/pool4_max.sv
// pool4_max: signed max of four samples (lower index wins ties), or sample 0 when bypassed
module pool4_max import cnn_pkg::*; #(
    parameter int DW = DEF_DW
) (
    input  logic [3:0][DW-1:0] s,
    input  logic               pool_en,
    output logic [DW-1:0]      y
);
    logic [DW-1:0] m01, m23;
    always_comb begin
        m01 = $signed(s[1]) > $signed(s[0]) ? s[1] : s[0];
        m23 = $signed(s[3]) > $signed(s[2]) ? s[3] : s[2];
        y   = !pool_en ? s[0] : $signed(m23) > $signed(m01) ? m23 : m01;
    end
endmodule

// File: rtl/pool_window_buf.sv
// pool_window_buf: pools each beat into per-channel frame buffers and streams KxK windows
// in row-major anchor order under a valid/ready handshake.
module pool_window_buf import cnn_pkg::*; #(
    parameter int DW  = DEF_DW,
    parameter int CH  = 2,
    parameter int MAP = 12,
    parameter int K   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pool_en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CH-1:0][3:0][DW-1:0]     din,
    input  logic                           frame_clr,
    input  logic                           win_ready,
    output logic                           win_valid,
    output logic [CH-1:0][K*K-1:0][DW-1:0] win,
    output logic                           frame_done
);
    localparam int N  = MAP * MAP;
    localparam int AW = $clog2(N + 1);
    localparam int RW = MAP > 1 ? $clog2(MAP) : 1;
    localparam logic [RW-1:0] LIM    = RW'(MAP - K);
    localparam logic [AW-1:0] BR_OFS = AW'((K - 1) * MAP + K - 1);

    state_t state, state_nx;
    logic [AW-1:0] wr_cnt, base;
    logic [RW-1:0] r, c;
    logic all_ld, acc, wr_en, avail, ld, fin, last;
    logic [CH-1:0][DW-1:0] pooled;
    logic [CH-1:0][K*K-1:0][DW-1:0] taps;
    logic [DW-1:0] mem [CH][N];

    for (genvar g = 0; g < CH; g++) begin : g_pool
        pool4_max #(.DW(DW)) u_pool (.s(din[g]), .pool_en(pool_en), .y(pooled[g]));
    end

    // all_ld marks the final anchor as loaded so no further window is fetched
    always_comb begin
        in_ready = wr_cnt < AW'(N) && state != DONE;
        acc      = in_valid && in_ready;
        wr_en    = acc && !frame_clr;
        base     = AW'(r) * AW'(MAP) + AW'(c);
        avail    = wr_cnt > base + BR_OFS;
        last     = r == LIM && c == LIM;
        ld       = state == RUN && !frame_clr && !all_ld && avail && (!win_valid || win_ready);
        fin      = state == RUN && !frame_clr && all_ld && win_valid && win_ready;
        state_nx = frame_clr ? IDLE : state == IDLE && acc ? RUN : fin ? DONE : state;
    end

    always_comb begin
        taps = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int t = 0; t < K * K; t++)
                taps[ch][t] = mem[ch][base + AW'((t / K) * MAP + t % K)];
    end

    always_ff @(posedge clk)
        if (wr_en)
            for (int ch = 0; ch < CH; ch++) mem[ch][wr_cnt] <= pooled[ch];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            r          <= '0;
            c          <= '0;
            all_ld     <= 1'b0;
            win_valid  <= 1'b0;
            win        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= fin;
            if (frame_clr) begin
                wr_cnt    <= '0;
                r         <= '0;
                c         <= '0;
                all_ld    <= 1'b0;
                win_valid <= 1'b0;
            end else begin
                if (wr_en) wr_cnt <= wr_cnt + 1'b1;
                if (ld) begin
                    win       <= taps;
                    win_valid <= 1'b1;
                    all_ld    <= last;
                    c         <= c == LIM ? '0 : c + 1'b1;
                    r         <= c == LIM ? r + 1'b1 : r;
                end else if (win_valid && win_ready) begin
                    win_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_window_buf.sv
// tb_pool_window_buf: randomized bench scoring every accepted window against a frame-array model
module tb_pool_window_buf;
    import cnn_pkg::*;
    localparam int DW = 18, CH = 2, MAP = 12, K = 3;
    localparam int NA = MAP - K + 1, NW = NA * NA, N = MAP * MAP, WB = CH * K * K * DW;

    logic clk = 0, rst_n = 0, pool_en = 1, in_valid = 0, frame_clr = 0, win_ready = 0;
    logic [CH-1:0][3:0][DW-1:0] din = '0;
    logic in_ready, win_valid, frame_done;
    logic [CH-1:0][K*K-1:0][DW-1:0] win;

    pool_window_buf #(.DW(DW), .CH(CH), .MAP(MAP), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .pool_en(pool_en), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .frame_clr(frame_clr), .win_ready(win_ready), .win_valid(win_valid),
        .win(win), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    sample_t pm [CH][N];
    int wr = 0, n = 0, g = 0;
    bit done = 0, ramp = 0, prev_hold = 0, fd_next = 0;
    logic [WB-1:0] prev_win;
    logic [511:0] v;
    logic [DW-1:0] e;
    int addrs [9] = '{0, 1, 2, 12, 13, 14, 24, 25, 26};

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic sample_t pool_ref(input logic [3:0][DW-1:0] s, input bit en);
        sample_t m = s[0];
        if (en)
            for (int j = 1; j < 4; j++) if ($signed(s[j]) > m) m = s[j];
        return m;
    endfunction

    function automatic logic [511:0] exp_win(input int idx);
        logic [511:0] x = '0;
        int r = idx / NA, c = idx % NA;
        for (int ch = 0; ch < CH; ch++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    x[(ch * K * K + ky * K + kx) * DW +: DW] = pm[ch][(r + ky) * MAP + c + kx];
        return x;
    endfunction

    // ramp beats pool to (write address + 1000*channel); otherwise fully random
    task automatic set_beat();
        int rot = $urandom_range(3);
        if (ramp) begin
            pool_en = 1'b1;
            for (int ch = 0; ch < CH; ch++)
                for (int j = 0; j < 4; j++)
                    din[ch][j] = DW'(wr + ch * 1000 - (j + rot) % 4);
        end else begin
            pool_en = ($urandom_range(1) == 1);
            for (int ch = 0; ch < CH; ch++)
                for (int j = 0; j < 4; j++) din[ch][j] = DW'($urandom);
        end
    endtask

    task automatic model_reset();
        wr = 0; n = 0; done = 0; prev_hold = 0;
    endtask

    task automatic tick();
        chk("in_ready", in_ready, wr < N && !done);
        if (prev_hold) chk("hold", {win_valid, win}, {1'b1, prev_win});
        prev_hold = win_valid && !win_ready && !frame_clr;
        prev_win = win;
        fd_next = 0;
        if (frame_clr) model_reset();
        else begin
            if (in_valid && wr < N && !done) begin
                for (int ch = 0; ch < CH; ch++) pm[ch][wr] = pool_ref(din[ch], pool_en);
                wr++;
            end
            if (win_valid && win_ready) begin
                if (n >= NW) chk("extra_win", 1, 0);
                else begin
                    chk("win", win, exp_win(n));
                    n++;
                    if (n == NW) begin done = 1; fd_next = 1; end
                end
            end
        end
        @(negedge clk);
        chk("frame_done", frame_done, fd_next);
    endtask

    task automatic frame_clear();
        frame_clr = 1; in_valid = 0; win_ready = 0;
        tick();
        frame_clr = 0;
    endtask

    task automatic run_frame(input int pv, input int pr, input int limit);
        int cyc = 0;
        while (!done && cyc < limit) begin
            in_valid = ($urandom_range(99) < pv);
            win_ready = ($urandom_range(99) < pr);
            set_beat();
            tick();
            cyc++;
        end
        chk("frame_timeout", done, 1);
        in_valid = 0; win_ready = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win", win, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1;

        // full ramp frame buffered first, then drained at one window per cycle
        ramp = 1; win_ready = 0;
        repeat (N) begin in_valid = 1; set_beat(); tick(); end
        in_valid = 1; set_beat(); tick();
        v = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int t = 0; t < 9; t++) v[(ch * 9 + t) * DW +: DW] = DW'(addrs[t] + ch * 1000);
        chk("first_valid", win_valid, 1);
        chk("first_win", win, v);
        in_valid = 0; win_ready = 1;
        repeat (NW) tick();
        chk("throughput", n, NW);
        tick();
        ramp = 0;

        for (int pe = 1; pe >= 0; pe--) begin
            frame_clear();
            set_beat();
            din[0] = {DW'(3), DW'(-7), DW'(3), DW'(-5)};
            pool_en = (pe == 1); in_valid = 1; win_ready = 0;
            tick();
            g = 0;
            while (!win_valid && g < 500) begin in_valid = 1; set_beat(); tick(); g++; end
            e = pe == 1 ? DW'(3) : DW'(-5);
            chk(pe == 1 ? "pool_max" : "pool_bypass", win[0][0], e);
            run_frame(70, 60, 3000);
        end

        // stall the consumer mid-frame; the hold check covers stability
        frame_clear();
        g = 0;
        while (n < 20 && g < 1000) begin in_valid = 1; win_ready = 1; set_beat(); tick(); g++; end
        chk("reach_20", n, 20);
        win_ready = 0;
        repeat (10) begin in_valid = ($urandom_range(1) == 1); set_beat(); tick(); end
        run_frame(80, 70, 3000);

        // slow input: first window must follow the 27th stored beat by exactly one cycle
        frame_clear();
        win_ready = 1;
        for (int b = 0; b < 27; b++) begin
            in_valid = 1; set_beat(); tick(); in_valid = 0;
            if (b < 26) repeat (3) begin chk("no_early", win_valid, 0); tick(); end
        end
        chk("lat_t0", win_valid, 0);
        tick();
        chk("lat_t1", win_valid, 1);
        run_frame(25, 100, 3000);
        in_valid = 1; set_beat(); tick(); in_valid = 0;

        // frame_clr beats a simultaneous input beat and handshake
        frame_clear();
        repeat (50) begin in_valid = 1; win_ready = 1; set_beat(); tick(); end
        frame_clr = 1; in_valid = 1; win_ready = 1; set_beat();
        tick();
        frame_clr = 0; in_valid = 0;
        chk("clr_valid", win_valid, 0);
        chk("clr_ready", in_ready, 1);
        run_frame(90, 80, 3000);

        // asynchronous reset around window 40, then a fresh reference frame
        frame_clear();
        ramp = 1; g = 0;
        while (n < 40 && g < 2000) begin
            in_valid = 1; win_ready = ($urandom_range(1) == 1); set_beat(); tick(); g++;
        end
        chk("reach_40", n, 40);
        #2 rst_n = 0;
        #1;
        chk("arst_win_valid", win_valid, 0);
        chk("arst_win", win, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_in_ready", in_ready, 1);
        model_reset();
        in_valid = 0; win_ready = 0;
        @(negedge clk);
        rst_n = 1;
        run_frame(100, 100, 3000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pool_window_buf.md
# pool_window_buf

Parametrised 2x2 max-pool and sliding-window buffer for the convolution pipeline, sitting between a conv layer's multiplier outputs and the next layer's MAC array. Each input beat carries four pre-pool samples per channel. The block reduces them to one pooled value per channel and stores it in a per-channel frame buffer. It then emits KxK windows, registered and in row-major scan order, under a valid/ready handshake, with pool bypass and end-of-frame signalling.

## Interface
- DW, 18: sample width, signed two's complement
- CH, 2: channel count
- MAP, 12: pooled feature-map side length; the buffer holds MAP*MAP entries per channel
- K, 3: window side length; requires 1 ≤ K ≤ MAP
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pool_en  in  1  1: output max of 4 samples; 0: bypass, output sample [0]; sampled per beat
- in_valid  in  1  input beat valid
- in_ready  out  1  buffer can accept a beat
- din  in  CH x 4 x DW  pre-pool samples per channel
- frame_clr  in  1  synchronous restart of a frame
- win_ready  in  1  consumer accepts the current window
- win_valid  out  1  win holds a valid window
- win  out  CH x K*K x DW  window taps, index ky*K+kx, row-major
- frame_done  out  1  one-cycle pulse after the last window is accepted

## Operation
- Write side:
  - A beat is accepted when in_valid && in_ready.
  - The pooled value for each channel is written to address wr_cnt, then wr_cnt increments.
  - Max uses a signed compare; on a tie, the lower index wins.
- in_ready = (wr_cnt < MAP*MAP) && state != DONE. Beats offered while in_ready=0 are ignored.
- Read anchor: row r and column c, with 0 ≤ r,c ≤ MAP-K, and base a = r*MAP + c. Tap (ky,kx) reads address a + ky*MAP + kx.
- Window available when wr_cnt > a + (K-1)*MAP + (K-1). This is the bottom-right tap written, and it includes a beat being written in the same cycle only if it is already stored. The write-before-read hazard is therefore excluded by the strict compare.
- FSM:
  - IDLE → RUN on the first accepted beat.
  - In RUN, when the window is available and the output register is empty or being accepted, load the window and advance the anchor.
  - Anchor advance: c+1; at c = MAP-K, wrap to c=0 and r+1.
  - After the window at r = c = MAP-K is accepted: pulse frame_done and go to DONE.
  - DONE → IDLE on frame_clr.
- frame_clr, in any state:
  - Clears wr_cnt, r, c and win_valid, and sets the state to IDLE.
  - Has priority over a simultaneous accepted beat or window handshake in the same cycle; the beat is dropped.
  - Buffer contents are not cleared.
- Arithmetic:
  - No width growth; the pooled value is DW bits.
  - Counter widths are $clog2(MAP*MAP+1) for wr_cnt and $clog2(MAP) for r and c.
  - K = MAP yields exactly one window.

## Timing
- Reset values:
  - in_ready = 1
  - win_valid = 0
  - win = 0
  - frame_done = 0
  - wr_cnt, r, c = 0
  - state = IDLE
- Write latency: a beat accepted at cycle t is readable at t+1.
- Window latency: win_valid rises 1 cycle after the availability condition is first true.
- Output hold: win and win_valid hold while win_valid && !win_ready.
- Throughput: one window per cycle once all input is buffered.
- frame_done asserts the cycle after the final handshake.
- Asynchronous reset mid-frame returns every output to its reset value immediately.

## Structure
- A shared package cnn_pkg holds:
  - the default DW
  - typedef sample_t = logic signed [DW-1:0]
  - the FSM state enum {IDLE, RUN, DONE}
- One sub-module, pool4_max: a combinational 4-input signed max with bypass. It is instantiated CH times.
- Per-channel storage is an inferred register array. Reads are multi-tap and combinational into the window register.

## Test plan
- Defaults, feed 144 beats with ramp values, pool_en=1 → 100 windows in order. The first window's taps are addresses {0,1,2,12,13,14,24,25,26}, and frame_done pulses once after window 100.
- Beat with din[0] = {-5, 3, -7, 3} and pool_en=1 → pooled value 3. With pool_en=0 → -5.
- Hold win_ready=0 for 10 cycles mid-frame → win is stable and no anchor advance occurs. On release, the next window is at c+1.
- Stream input slowly, one beat per 4 cycles → the first win_valid occurs exactly 1 cycle after beat 27 (address 26) is stored.
- Offer a 145th beat → in_ready=0 and the beat is ignored. frame_clr asserted together with in_valid → wr_cnt=0 and win_valid=0 next cycle.
- Assert rst_n low during RUN at window 40 → all outputs reset asynchronously. A fresh frame afterwards reproduces the reference window sequence.
